instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Instruction-fetch sequencer for the RISC-V core. It owns the fetch PC and issues word-aligned read requests to instruction memory over a req/gnt + rvalid handshake. It buffers each returned instruction and presents it to decode with a valid/ready handshake. Branch/jump redirects from execute are accepted in any state, and in-flight fetches are squashed.

Parameters:
ADDR_W, 64, fetch address / PC width
INSTR_W, 32, instruction width
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
redirect_valid  in  1  load redirect_pc as next fetch PC (1-cycle pulse)
redirect_pc  in  ADDR_W  redirect target
mem_req  out  1  instruction-memory read request
mem_addr  out  ADDR_W  read address; bits [1:0] always 0
mem_gnt  in  1  memory accepted request (meaningful only while mem_req=1)
mem_rvalid  in  1  read data valid (at least 1 cycle after gnt)
mem_rdata  in  INSTR_W  read data
inst_valid  out  1  inst_data/inst_pc valid to decode
inst_ready  in  1  decode consumes instruction
inst_data  out  INSTR_W  buffered instruction
inst_pc  out  ADDR_W  PC of inst_data
misalign_err  out  1  1-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (async, active-high; clk as above):
  - state=REQ, fetch_pc=RESET_PC.
  - Outputs: mem_req=0, mem_addr=0, inst_valid=0, inst_data=0, inst_pc=0, misalign_err=0, drop=0.
- All outputs are registered. mem_req=1 and mem_addr=fetch_pc appear in the first cycle after reset deasserts.
- State REQ:
  - mem_req=1 and mem_addr held stable until mem_gnt.
  - On mem_gnt: mem_req←0, state←WAIT.
- State WAIT:
  - mem_req=0.
  - On mem_rvalid with drop=0: inst_data←mem_rdata, inst_pc←fetch_pc, inst_valid←1, state←HOLD.
  - On mem_rvalid with drop=1: discard data, drop←0, state←REQ, mem_req←1, mem_addr←fetch_pc.
- State HOLD:
  - inst_valid=1; inst_data and inst_pc stable.
  - On inst_ready: inst_valid←0, fetch_pc←fetch_pc+4 (mod 2^ADDR_W; all-ones word address wraps to 0), state←REQ, mem_req←1 with new mem_addr.
- Throughput: minimum 3 cycles per instruction (REQ with gnt, WAIT with rvalid, HOLD with ready).
- Redirect (highest priority, any state):
  - Common action: fetch_pc←{redirect_pc[ADDR_W-1:2],2'b00}; misalign_err←1 for one cycle if redirect_pc[1:0]!=0.
  - REQ, no gnt that cycle: mem_addr←new PC, mem_req stays 1. Address change while ungranted is permitted.
  - REQ with gnt the same cycle: the granted request is in flight; drop←1, state←WAIT.
  - WAIT without rvalid: drop←1, stay WAIT.
  - WAIT with rvalid that cycle: data discarded, state←REQ with new PC.
  - HOLD: inst_valid←0 regardless of inst_ready (the instruction is not consumed by the fetch side; decode must ignore it), state←REQ.
  - A second redirect while drop=1 only updates fetch_pc; drop stays 1. Exactly one response is discarded.
- mem_rvalid outside WAIT is ignored. mem_gnt while mem_req=0 is ignored.
- Reset mid-transaction returns to the reset state immediately. A response arriving after reset is ignored, because state is REQ and not WAIT.

Test Plan:
- Reset release, RESET_PC=0, mem_gnt=1 in REQ, rvalid one cycle later with rdata=0x00500093, inst_ready=1 -> mem_addr 0x0, then 0x4 three cycles later; inst_data=0x00500093, inst_pc=0.
- inst_ready held low 5 cycles in HOLD -> inst_valid, inst_data and inst_pc stable; mem_req=0 throughout; after ready, mem_addr=pc+4.
- Redirect to 0x100 during WAIT, then rvalid with rdata=0xDEADBEEF -> data dropped, inst_valid stays 0; next mem_req has mem_addr=0x100, and the returned word is presented with inst_pc=0x100.
- Redirect to 0x203 while in REQ, gnt withheld -> misalign_err pulses 1 cycle; mem_addr becomes 0x200 next cycle, mem_req continuously 1.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC, instruction consumed -> next mem_addr=0x0.
- Async reset asserted mid-WAIT, late rvalid after release -> all outputs 0 during reset; late rvalid ignored; first request after release at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues word-aligned reads
// over a req/gnt + rvalid handshake, buffers each returned instruction for
// decode and squashes in-flight fetches when execute redirects the PC.
module instr_fetch_ctrl #(
  parameter int unsigned          ADDR_W   = 64,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic               misalign_err
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  // The reset PC is forced onto a word boundary so mem_addr[1:0] stays 0.
  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic                 drop_q, drop_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 inst_valid_q, inst_valid_d;
  logic [INSTR_W-1:0]   inst_data_q, inst_data_d;
  logic [ADDR_W-1:0]    inst_pc_q, inst_pc_d;
  logic                 misalign_err_q, misalign_err_d;

  logic [ADDR_W-1:0]    redirect_target;
  logic [ADDR_W-1:0]    next_seq_pc;
  logic                 granted;

  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign next_seq_pc     = fetch_pc_q + ADDR_W'(4);
  // A grant only counts while our request is actually on the bus.
  assign granted         = mem_req_q & mem_gnt;

  // Next-state logic: normal sequencing first, then redirect overrides it.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    drop_d         = drop_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    inst_valid_d   = inst_valid_q;
    inst_data_d    = inst_data_q;
    inst_pc_d      = inst_pc_q;
    misalign_err_d = 1'b0;

    unique case (state_q)
      REQ: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end else if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (drop_q) begin
            drop_d     = 1'b0;
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
          end else begin
            inst_data_d  = mem_rdata;
            inst_pc_d    = fetch_pc_q;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (inst_ready) begin
          inst_valid_d = 1'b0;
          fetch_pc_d   = next_seq_pc;
          state_d      = REQ;
          mem_req_d    = 1'b1;
          mem_addr_d   = next_seq_pc;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase

    if (redirect_valid) begin
      fetch_pc_d     = redirect_target;
      misalign_err_d = |redirect_pc[1:0];
      unique case (state_q)
        REQ: begin
          if (granted) begin
            mem_req_d = 1'b0;
            drop_d    = 1'b1;
            state_d   = WAIT;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = redirect_target;
            state_d    = REQ;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            drop_d       = 1'b0;
            inst_valid_d = inst_valid_q;
            inst_data_d  = inst_data_q;
            inst_pc_d    = inst_pc_q;
            state_d      = REQ;
            mem_req_d    = 1'b1;
            mem_addr_d   = redirect_target;
          end else begin
            drop_d = 1'b1;
          end
        end
        HOLD: begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
          mem_req_d    = 1'b1;
          mem_addr_d   = redirect_target;
        end
        default: begin
          state_d = REQ;
        end
      endcase
    end
  end

  // State and registered outputs; reset returns straight to the request phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= REQ;
      fetch_pc_q     <= RESET_PC_ALIGNED;
      drop_q         <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      inst_valid_q   <= 1'b0;
      inst_data_q    <= '0;
      inst_pc_q      <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      drop_q         <= drop_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      inst_valid_q   <= inst_valid_d;
      inst_data_q    <= inst_data_d;
      inst_pc_q      <= inst_pc_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign inst_valid   = inst_valid_q;
  assign inst_data    = inst_data_q;
  assign inst_pc      = inst_pc_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios followed by
// randomized bus/decode/redirect traffic, all checked against a
// transaction-level model of the fetch unit kept here.
module tb_instr_fetch_ctrl;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] RST_PC = '0;

  logic               clk;
  logic               reset;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;
  logic               inst_valid;
  logic               inst_ready;
  logic [INSTR_W-1:0] inst_data;
  logic [ADDR_W-1:0]  inst_pc;
  logic               misalign_err;

  int checks   = 0;
  int failures = 0;

  // Model: what the fetch unit is doing, expressed as pending activities.
  bit                 m_req;        // request is on the bus
  bit                 m_waiting;    // a granted request awaits its response
  bit                 m_discard;    // the awaited response must be thrown away
  bit                 m_present;    // an instruction is offered to decode
  bit                 m_mis;
  logic [ADDR_W-1:0]  m_pc;
  logic [ADDR_W-1:0]  m_addr;
  logic [INSTR_W-1:0] m_inst;
  logic [ADDR_W-1:0]  m_ipc;

  instr_fetch_ctrl #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_waiting = 0; m_discard = 0; m_present = 0; m_mis = 0;
    m_pc = RST_PC; m_addr = '0; m_inst = '0; m_ipc = '0;
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_step();
    bit granted, resp;
    logic [ADDR_W-1:0] tgt;
    granted = m_req && mem_gnt;
    resp    = m_waiting && mem_rvalid;
    tgt     = {redirect_pc[ADDR_W-1:2], 2'b00};
    m_mis   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      m_pc = tgt;
      if (granted) begin
        m_req = 0; m_waiting = 1; m_discard = 1;
      end else if (m_waiting && !resp) begin
        m_discard = 1;
      end else if (resp) begin
        m_waiting = 0; m_discard = 0; m_req = 1; m_addr = tgt;
      end else begin
        m_present = 0; m_req = 1; m_addr = tgt;
      end
    end else if (granted) begin
      m_req = 0; m_waiting = 1;
    end else if (resp) begin
      m_waiting = 0;
      if (m_discard) begin
        m_discard = 0; m_req = 1; m_addr = m_pc;
      end else begin
        m_present = 1; m_inst = mem_rdata; m_ipc = m_pc;
      end
    end else if (m_present && inst_ready) begin
      m_present = 0; m_pc = m_pc + 64'd4; m_req = 1; m_addr = m_pc;
    end else if (!m_req && !m_waiting && !m_present) begin
      m_req = 1; m_addr = m_pc;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".mem_req"},      64'(mem_req),      64'(m_req));
    check({tag, ".mem_addr"},     64'(mem_addr),     64'(m_addr));
    check({tag, ".inst_valid"},   64'(inst_valid),   64'(m_present));
    check({tag, ".inst_data"},    64'(inst_data),    64'(m_inst));
    check({tag, ".inst_pc"},      64'(inst_pc),      64'(m_ipc));
    check({tag, ".misalign_err"}, 64'(misalign_err), 64'(m_mis));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic idle_inputs();
    redirect_valid = 0; redirect_pc = '0; mem_gnt = 0;
    mem_rvalid = 0; mem_rdata = '0; inst_ready = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    reset = 1'b0;

    // Basic fetch: request at 0, consume, next request at 4.
    step("first_req");
    check("first_addr", 64'(mem_addr), 64'h0);
    check("first_req_hi", 64'(mem_req), 64'h1);
    mem_gnt = 1; step("gnt0");
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00500093; step("rvalid0");
    check("inst_data0", 64'(inst_data), 64'h00500093);
    check("inst_pc0", 64'(inst_pc), 64'h0);
    mem_rvalid = 0; inst_ready = 1; step("ready0");
    check("addr4", 64'(mem_addr), 64'h4);
    inst_ready = 0;

    // Decode stalls for five cycles in HOLD.
    mem_gnt = 1; step("gnt1");
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = $urandom; step("rvalid1");
    mem_rvalid = 0;
    for (int i = 0; i < 5; i++) step("stall");
    check("stall_req_low", 64'(mem_req), 64'h0);
    inst_ready = 1; step("ready1");
    check("addr8", 64'(mem_addr), 64'h8);
    inst_ready = 0;

    // Redirect during WAIT squashes the in-flight response.
    mem_gnt = 1; step("gnt2");
    mem_gnt = 0; redirect_valid = 1; redirect_pc = 64'h100; step("redir_wait");
    redirect_valid = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; step("dropped");
    check("drop_no_valid", 64'(inst_valid), 64'h0);
    check("redir_addr", 64'(mem_addr), 64'h100);
    mem_rvalid = 0; mem_gnt = 1; step("gnt3");
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h12345678; step("rvalid3");
    check("redir_inst_pc", 64'(inst_pc), 64'h100);
    mem_rvalid = 0; inst_ready = 1; step("ready3");
    inst_ready = 0;

    // Misaligned redirect in REQ without a grant.
    redirect_valid = 1; redirect_pc = 64'h203; step("redir_mis");
    check("mis_pulse", 64'(misalign_err), 64'h1);
    check("mis_addr", 64'(mem_addr), 64'h200);
    redirect_valid = 0; step("mis_after");
    check("mis_clear", 64'(misalign_err), 64'h0);
    check("mis_req_hi", 64'(mem_req), 64'h1);

    // PC wrap at the top of the address space.
    redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; step("redir_top");
    redirect_valid = 0; mem_gnt = 1; step("gnt4");
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = $urandom; step("rvalid4");
    mem_rvalid = 0; inst_ready = 1; step("ready4");
    check("wrap_addr", 64'(mem_addr), 64'h0);
    inst_ready = 0;

    // Asynchronous reset in WAIT, late response after release.
    mem_gnt = 1; step("gnt5");
    mem_gnt = 0;
    reset = 1'b1;
    #2;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("in_reset");
    reset = 1'b0;
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; step("late_rvalid");
    check("post_reset_addr", 64'(mem_addr), 64'(RST_PC));
    check("post_reset_noinst", 64'(inst_valid), 64'h0);
    mem_rvalid = 0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      mem_gnt        = ($urandom_range(0, 99) < 50);
      mem_rvalid     = ($urandom_range(0, 99) < 40);
      mem_rdata      = $urandom;
      inst_ready     = ($urandom_range(0, 99) < 50);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      step("rand");
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
